// File: rtl/ap_pkg.sv
// Shared definitions for the associative-processor host controller:
// FSM state encoding, column indices, AP command codes and clogb2.
package ap_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        APRST    = 4'd1,
        LD_ACC   = 4'd2,
        WA_SET   = 4'd3,
        WA_HOLD  = 4'd4,
        WB_SET   = 4'd5,
        WB_HOLD  = 4'd6,
        RUN      = 4'd7,
        RD_ISSUE = 4'd8,
        RD_WAIT  = 4'd9,
        RD_OUT   = 4'd10,
        FIN      = 4'd11
    } ap_state_t;

    localparam logic [1:0] COL_A = 2'd0;
    localparam logic [1:0] COL_B = 2'd1;
    localparam logic [1:0] COL_C = 2'd2;

    localparam logic [2:0] AP_CMD_OR  = 3'd0;
    localparam logic [2:0] AP_CMD_AND = 3'd1;
    localparam logic [2:0] AP_CMD_XOR = 3'd2;
    localparam logic [2:0] AP_CMD_ADD = 3'd3;
    localparam logic [2:0] AP_CMD_SUB = 3'd4;

    // Ceiling log2, never below 1 so a single-cell AP still gets a 1-bit address.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/ap_host_rd_stage.sv
// Read-back stage: waits READ_LAT cycles after a read strobe, captures the
// AP column-C word and holds it on a valid/ready result port until taken.
// READ_LAT must be at least 1.
module ap_host_rd_stage #(
    parameter int WORD_SIZE = 8,
    parameter int READ_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] ap_data_out,
    input  logic                 res_ready,
    output logic                 cap,
    output logic                 res_valid,
    output logic [WORD_SIZE-1:0] res_data
);

    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    logic          waiting;
    logic [CW-1:0] cnt;

    // The capture cycle is the READ_LAT-th cycle after the strobe cycle.
    assign cap = waiting && (cnt == CW'(READ_LAT - 1));

    // Latency counter armed by the read strobe, disarmed at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waiting <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            waiting <= 1'b1;
            cnt     <= '0;
        end else if (cap) begin
            waiting <= 1'b0;
            cnt     <= '0;
        end else if (waiting) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Result holding register; data stays frozen while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (cap) begin
            res_valid <= 1'b1;
            res_data  <= ap_data_out;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ap_host_ctrl.sv
// Host-side initiator for the associative processor: loads operand pairs
// into columns A/B, runs the AP until its IRQ, streams column C back out.
// Optional watchdog on the RUN phase is enabled with `define AP_TIMEOUT_EN.
//
// Handshakes (opnd_*, res_*): a beat transfers on a rising clock edge where
// valid and ready are both high; the producer keeps valid and data stable
// until that edge, and ready may depend on nothing but controller state.
module ap_host_ctrl
    import ap_pkg::*;
#(
    parameter int WORD_SIZE   = 8,
    parameter int CELL_QUANT  = 512,
    parameter int READ_LAT    = 2,
    parameter int TIMEOUT_CYC = 256,
    localparam int AW         = clogb2(CELL_QUANT)
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW:0]          n_cells,
    input  logic [2:0]           op_cmd,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 opnd_valid,
    output logic                 opnd_ready,
    input  logic [WORD_SIZE-1:0] opnd_a,
    input  logic [WORD_SIZE-1:0] opnd_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WORD_SIZE-1:0] res_data,
    output logic                 res_last,
    output logic                 ap_rst,
    output logic [AW-1:0]        ap_addr,
    output logic [WORD_SIZE-1:0] ap_data,
    output logic                 ap_write_en,
    output logic                 ap_read_en,
    output logic                 ap_mode,
    output logic [1:0]           ap_sel_col,
    output logic                 ap_sel_internal_col,
    output logic [2:0]           ap_cmd,
    input  logic [WORD_SIZE-1:0] ap_data_out,
    input  logic                 ap_state_irq,
    output logic [3:0]           state_dbg
);

    ap_state_t            state;
    ap_state_t            next_state;
    logic [AW-1:0]        addr;
    logic [AW:0]          n_reg;
    logic [AW:0]          n_clamp;
    logic [2:0]           cmd_reg;
    logic [WORD_SIZE-1:0] a_reg;
    logic [WORD_SIZE-1:0] b_reg;
    logic                 is_last;
    logic                 rd_cap;
    logic                 tmo_hit;
    logic                 accept;

    assign accept    = (state == IDLE) && start;
    assign n_clamp   = (n_cells > (AW+1)'(CELL_QUANT)) ? (AW+1)'(CELL_QUANT) : n_cells;
    assign is_last   = ({1'b0, addr} == (n_reg - (AW+1)'(1)));
    assign state_dbg = state;

`ifdef AP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    // Fires on the last permitted RUN cycle when the AP is still silent.
    assign tmo_hit = (state == RUN) && !ap_state_irq && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign err     = err_q;

    // Counts cycles spent in RUN; cleared whenever the FSM is elsewhere.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == RUN) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Sticky error: set by a watchdog expiry, cleared by the next accepted job.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    ap_host_rd_stage #(
        .WORD_SIZE (WORD_SIZE),
        .READ_LAT  (READ_LAT)
    ) u_rd_stage (
        .clk         (CLK100MHZ),
        .rst         (rst),
        .start       (state == RD_ISSUE),
        .ap_data_out (ap_data_out),
        .res_ready   (res_ready),
        .cap         (rd_cap),
        .res_valid   (res_valid),
        .res_data    (res_data)
    );

    // FSM state register.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        next_state          = state;
        busy                = (state != IDLE);
        done                = 1'b0;
        opnd_ready          = 1'b0;
        res_last            = 1'b0;
        ap_rst              = 1'b0;
        ap_addr             = addr;
        ap_data             = '0;
        ap_write_en         = 1'b0;
        ap_read_en          = 1'b0;
        ap_mode             = 1'b0;
        ap_sel_col          = COL_A;
        ap_sel_internal_col = 1'b0;
        ap_cmd              = 3'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (n_cells == '0) ? FIN : APRST;
                end
            end
            APRST: begin
                ap_rst     = 1'b1;
                next_state = LD_ACC;
            end
            LD_ACC: begin
                opnd_ready = 1'b1;
                if (opnd_valid) next_state = WA_SET;
            end
            WA_SET: begin
                ap_write_en = 1'b1;
                ap_sel_col  = COL_A;
                ap_data     = a_reg;
                next_state  = WA_HOLD;
            end
            WA_HOLD: begin
                ap_sel_col = COL_A;
                ap_data    = a_reg;
                next_state = WB_SET;
            end
            WB_SET: begin
                ap_write_en = 1'b1;
                ap_sel_col  = COL_B;
                ap_data     = b_reg;
                next_state  = WB_HOLD;
            end
            WB_HOLD: begin
                ap_sel_col = COL_B;
                ap_data    = b_reg;
                next_state = is_last ? RUN : LD_ACC;
            end
            RUN: begin
                ap_mode = 1'b1;
                ap_cmd  = cmd_reg;
                if (ap_state_irq) begin
                    next_state = RD_ISSUE;
                end else if (tmo_hit) begin
                    next_state = FIN;
                end
            end
            RD_ISSUE: begin
                ap_read_en = 1'b1;
                ap_sel_col = COL_C;
                next_state = RD_WAIT;
            end
            RD_WAIT: begin
                ap_sel_col = COL_C;
                if (rd_cap) next_state = RD_OUT;
            end
            RD_OUT: begin
                ap_sel_col = COL_C;
                res_last   = is_last;
                if (res_valid && res_ready) begin
                    next_state = is_last ? FIN : RD_ISSUE;
                end
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Job parameters latched when a start is accepted.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            n_reg   <= '0;
            cmd_reg <= 3'd0;
        end else if (accept) begin
            n_reg   <= n_clamp;
            cmd_reg <= op_cmd;
        end
    end

    // Operand pair register, loaded on each accepted operand beat.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if ((state == LD_ACC) && opnd_valid) begin
            a_reg <= opnd_a;
            b_reg <= opnd_b;
        end
    end

    // Cell address: walks 0..n-1 for the load phase, then again for read-back.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else begin
            case (state)
                APRST:   addr <= '0;
                WB_HOLD: if (!is_last) addr <= addr + AW'(1);
                RUN:     if (ap_state_irq) addr <= '0;
                RD_OUT:  if (res_valid && res_ready && !is_last) addr <= addr + AW'(1);
                FIN:     addr <= '0;
                default: addr <= addr;
            endcase
        end
    end

endmodule

// File: tb/tb_ap_host_ctrl.sv
// Bench for ap_host_ctrl with a behavioural associative-processor model.
// Build with +define+AP_TIMEOUT_EN to also exercise the RUN watchdog.
module tb_ap_host_ctrl;
    import ap_pkg::*;

    localparam int WS  = 8;
    localparam int CQ  = 512;
    localparam int RL  = 2;
    localparam int TMO = 16;
    localparam int AW  = clogb2(CQ);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   n_cells;
    logic [2:0]    op_cmd;
    logic          busy, done, err;
    logic          opnd_valid, opnd_ready;
    logic [WS-1:0] opnd_a, opnd_b;
    logic          res_valid, res_ready, res_last;
    logic [WS-1:0] res_data;
    logic          ap_rst, ap_write_en, ap_read_en, ap_mode, ap_sel_internal_col;
    logic [AW-1:0] ap_addr;
    logic [WS-1:0] ap_data, ap_data_out;
    logic [1:0]    ap_sel_col;
    logic [2:0]    ap_cmd;
    logic          ap_state_irq;
    logic [3:0]    state_dbg;

    int total = 0;
    int bad   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    ap_host_ctrl #(
        .WORD_SIZE(WS), .CELL_QUANT(CQ), .READ_LAT(RL), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK100MHZ(clk), .rst(rst), .start(start), .n_cells(n_cells), .op_cmd(op_cmd),
        .busy(busy), .done(done), .err(err),
        .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_a(opnd_a), .opnd_b(opnd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .ap_rst(ap_rst), .ap_addr(ap_addr), .ap_data(ap_data), .ap_write_en(ap_write_en),
        .ap_read_en(ap_read_en), .ap_mode(ap_mode), .ap_sel_col(ap_sel_col),
        .ap_sel_internal_col(ap_sel_internal_col), .ap_cmd(ap_cmd),
        .ap_data_out(ap_data_out), .ap_state_irq(ap_state_irq), .state_dbg(state_dbg)
    );

    // Functional meaning of each AP command on one cell.
    function automatic logic [WS-1:0] ref_op(input logic [2:0] c, input logic [WS-1:0] a, input logic [WS-1:0] b);
        case (c)
            AP_CMD_OR:  return a | b;
            AP_CMD_AND: return a & b;
            AP_CMD_XOR: return a ^ b;
            AP_CMD_ADD: return a + b;
            AP_CMD_SUB: return a - b;
            default:    return '0;
        endcase
    endfunction

    // ---------------- AP slave model ----------------
    logic [WS-1:0] col_a [CQ];
    logic [WS-1:0] col_b [CQ];
    logic [WS-1:0] col_c [CQ];
    logic [WS-1:0] rd_pipe [RL];
    bit            no_irq = 1'b0;
    int            run_delay = 2;
    int            run_cnt;

    always @(posedge clk) begin
        if (rst) begin
            ap_state_irq <= 1'b0;
            run_cnt      <= 0;
        end else begin
            if (ap_rst) begin
                for (int i = 0; i < CQ; i++) begin
                    col_a[i] <= '0; col_b[i] <= '0; col_c[i] <= '0;
                end
            end
            if (ap_write_en && ap_sel_col == 2'd0) col_a[ap_addr] <= ap_data;
            if (ap_write_en && ap_sel_col == 2'd1) col_b[ap_addr] <= ap_data;
            if (ap_mode && !ap_state_irq && !no_irq) begin
                if (run_cnt >= run_delay) begin
                    for (int i = 0; i < CQ; i++) col_c[i] <= ref_op(ap_cmd, col_a[i], col_b[i]);
                    ap_state_irq <= 1'b1;
                end else begin
                    run_cnt <= run_cnt + 1;
                end
            end
            if (!ap_mode) begin
                ap_state_irq <= 1'b0;
                run_cnt      <= 0;
            end
        end
        // Off-time reads return the complement so a mistimed capture is visible.
        rd_pipe[0] <= ap_read_en ? col_c[ap_addr] : ~col_c[ap_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ap_data_out = rd_pipe[RL-1];

    // ---------------- monitor ----------------
    logic [WS-1:0] got_q [$];
    logic [WS-1:0] exp_q [$];
    int done_cnt = 0, aprst_cnt = 0, wr_cnt = 0, rd_cnt = 0, mode_cnt = 0, opnd_cnt = 0;
    int last_cnt = 0, last_beat = -1, last_waddr = -1, stall_err = 0, hold_err = 0;
    logic          prev_stall = 1'b0, prev_we = 1'b0;
    logic [WS-1:0] prev_res, prev_wd;
    logic [AW-1:0] prev_wa;
    logic [1:0]    prev_ws;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_we    = 1'b0;
        end else begin
            if (done)        done_cnt++;
            if (ap_rst)      aprst_cnt++;
            if (ap_write_en) begin wr_cnt++; last_waddr = int'(ap_addr); end
            if (ap_read_en)  rd_cnt++;
            if (ap_mode)     mode_cnt++;
            if (opnd_valid && opnd_ready) opnd_cnt++;
            if (res_valid && res_ready) begin
                got_q.push_back(res_data);
                if (res_last) begin last_cnt++; last_beat = got_q.size() - 1; end
            end
            if (prev_stall && (!res_valid || res_data !== prev_res)) stall_err++;
            prev_stall = res_valid && !res_ready;
            prev_res   = res_data;
            if (prev_we && (ap_write_en || ap_addr !== prev_wa || ap_sel_col !== prev_ws || ap_data !== prev_wd))
                hold_err++;
            prev_we = ap_write_en;
            prev_wa = ap_addr;
            prev_ws = ap_sel_col;
            prev_wd = ap_data;
        end
    end

    // ---------------- checking / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [WS-1:0] op_a [1024];
    logic [WS-1:0] op_b [1024];

    task automatic fill_random(input int n);
        for (int i = 0; i < n && i < 1024; i++) begin
            op_a[i] = WS'($urandom);
            op_b[i] = WS'($urandom);
        end
    endtask

    // Runs one job from op_a/op_b and checks everything observable about it.
    task automatic run_job(input int n, input logic [2:0] cmd, input bit bp, input bit gap,
                           input bit mid_start, input bit tmo);
        int eff, eff_res, base, d0, a0, w0, r0, o0, l0, idx, cyc;
        bit fire, seen;
        eff     = (n > CQ) ? CQ : n;
        eff_res = tmo ? 0 : eff;
        base = got_q.size();
        d0 = done_cnt; a0 = aprst_cnt; w0 = wr_cnt; r0 = rd_cnt; o0 = opnd_cnt; l0 = last_cnt;
        for (int i = 0; i < eff_res; i++) exp_q.push_back(ref_op(cmd, op_a[i], op_b[i]));
        run_delay = $urandom_range(1, 6);
        @(posedge clk); #1;
        start = 1'b1; n_cells = (AW+1)'(n); op_cmd = cmd;
        @(posedge clk); #1;
        start = 1'b0; n_cells = (AW+1)'(1); op_cmd = ~cmd;
        idx = 0; cyc = 0; seen = 1'b0; opnd_valid = 1'b0;
        while (!seen && cyc < 20000) begin
            if (!opnd_valid) opnd_valid = (idx < eff) && (!gap || $urandom_range(0, 2) == 0);
            opnd_a    = op_a[idx];
            opnd_b    = op_b[idx];
            res_ready = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            start     = mid_start && (cyc == 40);
            @(negedge clk);
            fire = opnd_valid && opnd_ready;
            if (done) seen = 1'b1;
            @(posedge clk); #1;
            if (fire) begin idx++; opnd_valid = 1'b0; end
            cyc++;
        end
        start = 1'b0; opnd_valid = 1'b0; res_ready = 1'b0;
        check("job_finished", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("opnd_beats", 32'(opnd_cnt - o0), 32'(eff));
        check("write_strobes", 32'(wr_cnt - w0), 32'(2 * eff));
        check("ap_rst_pulses", 32'(aprst_cnt - a0), (eff > 0) ? 32'd1 : 32'd0);
        check("read_strobes", 32'(rd_cnt - r0), 32'(eff_res));
        check("res_beats", 32'(got_q.size() - base), 32'(eff_res));
        if (eff > 0) check("last_waddr", 32'(last_waddr), 32'(eff - 1));
        if (eff_res > 0) begin
            check("res_last_cnt", 32'(last_cnt - l0), 32'd1);
            check("res_last_pos", 32'(last_beat), 32'(base + eff_res - 1));
        end
        for (int i = 0; i < eff_res; i++) begin
            if (base + i < got_q.size()) check($sformatf("res[%0d]", i), 32'(got_q[base + i]), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        exp_q.delete();
        check("stall_stable", 32'(stall_err), 32'd0);
        check("write_hold", 32'(hold_err), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc, d0, a0, w0, m0, r0, n;
        rst = 1'b1; start = 1'b0; n_cells = '0; op_cmd = 3'd0;
        opnd_valid = 1'b0; opnd_a = '0; opnd_b = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_flags", 32'({busy, done, err, opnd_ready, res_valid, res_last, ap_rst,
                                 ap_write_en, ap_read_en, ap_mode, ap_sel_internal_col}), 32'd0);
        check("rst_addr", 32'(ap_addr), 32'd0);
        check("rst_data", 32'({ap_data, res_data, ap_sel_col, ap_cmd}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic job
        op_a[0] = 8'h0F; op_a[1] = 8'hA0; op_a[2] = 8'h00; op_a[3] = 8'hFF;
        op_b[0] = 8'hF0; op_b[1] = 8'h05; op_b[2] = 8'h00; op_b[3] = 8'h01;
        run_job(4, AP_CMD_OR, 1'b0, 1'b0, 1'b0, 1'b0);
        // Same job under backpressure and gapped operands
        run_job(4, AP_CMD_OR, 1'b1, 1'b1, 1'b0, 1'b0);

        // Zero length: done in the cycle after the start edge, no AP activity
        d0 = done_cnt; a0 = aprst_cnt; w0 = wr_cnt; m0 = mode_cnt; r0 = rd_cnt;
        @(posedge clk); #1;
        start = 1'b1; n_cells = '0; op_cmd = AP_CMD_AND;
        @(negedge clk);
        check("zl_done_early", 32'({done, busy}), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zl_done_busy", 32'({done, busy}), 32'b11);
        @(negedge clk);
        check("zl_idle", 32'({done, busy}), 32'd0);
        check("zl_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("zl_quiet", 32'((aprst_cnt - a0) + (wr_cnt - w0) + (mode_cnt - m0) + (rd_cnt - r0)), 32'd0);

        // Randomized jobs
        for (int j = 0; j < 4; j++) begin
            n = $urandom_range(1, 20);
            fill_random(n);
            run_job(n, 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        // Clamp to CELL_QUANT, with an ignored mid-job start
        fill_random(600);
        run_job(600, AP_CMD_XOR, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset during RUN
        no_irq = 1'b1;
        fill_random(3);
        @(posedge clk); #1;
        start = 1'b1; n_cells = (AW+1)'(3); op_cmd = AP_CMD_AND;
        @(posedge clk); #1;
        start = 1'b0; opnd_valid = 1'b1; opnd_a = op_a[0]; opnd_b = op_b[0]; res_ready = 1'b1;
        cyc = 0;
        while (!ap_mode && cyc < 200) begin @(negedge clk); cyc++; end
        check("mid_rst_reached_run", 32'(ap_mode), 32'd1);
        opnd_valid = 1'b0;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_async", 32'({ap_mode, busy, res_valid}), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        no_irq = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        fill_random(5);
        run_job(5, AP_CMD_SUB, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef AP_TIMEOUT_EN
        // Watchdog: AP never answers
        no_irq = 1'b1;
        m0 = mode_cnt;
        fill_random(2);
        run_job(2, AP_CMD_OR, 1'b0, 1'b0, 1'b0, 1'b1);
        check("tmo_mode_cycles", 32'(mode_cnt - m0), 32'(TMO));
        check("tmo_err_set", 32'(err), 32'd1);
        no_irq = 1'b0;
        run_job(0, AP_CMD_OR, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tmo_err_cleared", 32'(err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ap_host_ctrl.md
Name: ap_host_ctrl

Overview:
- Host-side initiator for the associative-processor slave (columns A/B/C, bit-serial compare/write engine).
- Accepts a job (cell count, AP command), streams operand pairs into columns A and B, runs the AP until it raises its completion IRQ, then reads column C back as a result stream.
- Sits between the system datapath (valid/ready streams) and the AP's addr/data/write_en/read_en/ap_mode pins.

Parameters:
- WORD_SIZE, 8, AP cell width in bits.
- CELL_QUANT, 512, number of AP cells; AW = clogb2(CELL_QUANT).
- READ_LAT, 2, cycles from ap_read_en to valid ap_data_out.
- TIMEOUT_CYC, 256, watchdog limit in cycles; used only with AP_TIMEOUT_EN.

Ports:
- CLK100MHZ  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- n_cells  in  AW+1  number of cells for the job; values above CELL_QUANT clamp to CELL_QUANT.
- op_cmd  in  3  AP command, latched at start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag; constant 0 without AP_TIMEOUT_EN.
- opnd_valid / opnd_ready  in / out  1  operand handshake.
- opnd_a, opnd_b  in  WORD_SIZE  operands for columns A and B.
- res_valid / res_ready  out / in  1  result handshake.
- res_data  out  WORD_SIZE  column C value.
- res_last  out  1  marks the final result beat.
- ap_rst  out  1  one-cycle AP reinitialisation pulse.
- ap_addr  out  AW  AP cell address.
- ap_data  out  WORD_SIZE  AP write data.
- ap_write_en, ap_read_en, ap_mode  out  1  AP strobes.
- ap_sel_col  out  2  column select: 0=A, 1=B, 2=C.
- ap_sel_internal_col  out  1  tied 0.
- ap_cmd  out  3  AP command.
- ap_data_out  in  WORD_SIZE  AP read data.
- ap_state_irq  in  1  AP completion flag.

Behaviour:
- One clock, CLK100MHZ. rst is asynchronous and active-high.
- Reset state: all outputs 0, FSM in IDLE, counters 0. A reset mid-job aborts immediately: ap_mode drops, no done pulse is issued, and any pending result beat is discarded.
- FSM states: IDLE, APRST, LD_ACC, WA_SET, WA_HOLD, WB_SET, WB_HOLD, RUN, RD_ISSUE, RD_WAIT, RD_OUT, FIN.
- IDLE:
  - start=1 latches op_cmd and the clamped n_cells, and clears err.
  - If n_cells=0: go to FIN (done pulses on the next cycle; no AP pins toggle).
  - Otherwise: go to APRST.
  - start asserted in any other state is ignored.
- APRST: ap_rst=1 for exactly one cycle, then go to LD_ACC with addr=0.
- LD_ACC: opnd_ready=1. On opnd_valid, register A and B, then go to WA_SET.
- Write sequence, two cycles per column (the AP registers data and write-enable one cycle after write_en):
  - WA_SET: write_en=1, sel_col=0, ap_data=A.
  - WA_HOLD: write_en=0, addr/sel_col/ap_data held.
  - WB_SET and WB_HOLD: the same for sel_col=1 with B.
  - After WB_HOLD: if addr=n-1, go to RUN; otherwise addr+1 and return to LD_ACC.
  - Minimum cost is 5 cycles per cell.
- RUN:
  - ap_mode=1, ap_cmd=latched op_cmd.
  - Stay until ap_state_irq=1; on that cycle ap_mode is cleared (registered, so low on the next cycle).
  - Then go to RD_ISSUE with addr=0.
- RD_ISSUE: ap_read_en=1 and sel_col=2 for one cycle.
- RD_WAIT: count READ_LAT cycles with addr and sel_col held, then capture ap_data_out into res_data.
- RD_OUT:
  - res_valid=1 with res_data held stable until res_ready=1.
  - res_last=1 when addr=n-1.
  - On handshake: if last, go to FIN; otherwise addr+1 and go to RD_ISSUE.
- FIN: done=1 for one cycle, busy drops, return to IDLE.
- busy is high in every state except IDLE.

Optional Feature:
- Macro AP_TIMEOUT_EN.
- Defined: a cycle counter runs in RUN. If it reaches TIMEOUT_CYC without ap_state_irq, then ap_mode drops, err=1, the read phase is skipped, and the FSM goes to FIN. err stays set until the next accepted start.
- Undefined: RUN waits indefinitely; err is tied 0; no counter logic.

Decomposition:
- Package ap_pkg:
  - FSM state enum.
  - Column indices COL_A=0, COL_B=1, COL_C=2.
  - AP command codes.
  - clogb2 function.
- Sub-module ap_host_rd_stage: READ_LAT delay counter plus result holding register with valid/ready. The main block keeps the FSM, the address counter and the write sequencing.

Test Plan:
- Basic job: n_cells=4, op_cmd=OR, A={0x0F,0xA0,0x00,0xFF}, B={0xF0,0x05,0x00,0x01}, AP model attached -> column writes at addr 0..3 with 2-cycle holds; results 0xFF, 0xA5, 0x00, 0xFF; res_last on beat 4; one done pulse.
- Backpressure: same job with res_ready toggling 1-of-3 cycles and opnd_valid gapped -> identical data, res_data stable while stalled, no duplicated or skipped beats.
- Zero length: n_cells=0 -> done one cycle after IDLE exit; ap_rst, ap_write_en, ap_mode and ap_read_en never toggle.
- Clamp and protocol checks: n_cells=600 with CELL_QUANT=512 -> exactly 512 operand beats accepted, last address 511; a start pulsed mid-job is ignored.
- Reset mid-operation: assert rst during RUN -> ap_mode and busy are 0 immediately (async); no done; a fresh job then completes correctly.
- Timeout (AP_TIMEOUT_EN, TIMEOUT_CYC=16): ap_state_irq held 0 -> ap_mode drops after 16 RUN cycles, err=1, done pulses, zero result beats; the next start clears err.
